down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 92 +++++++++
 tb/tb_down_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down-counter with one-shot and periodic modes, a registered
// terminal-count pulse and IDLE/RUN/DONE status flags.
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic [WIDTH-1:0] reload, reload_next;
    logic             tc_next;
    logic             busy_q, done_q, tc_q;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        tc_next     = 1'b0;

        if (abort) begin
            state_next = IDLE;
            count_next = ZERO;
        end else if (load) begin
            count_next  = load_value;
            reload_next = load_value;
            state_next  = (load_value != ZERO) ? RUN : DONE;
        end else if (state == RUN && enable) begin
            if (count > ONE) begin
                count_next = count - ONE;
            end else if (count == ONE) begin
                tc_next = 1'b1;
                if (auto_reload) begin
                    count_next = reload;
                end else begin
                    count_next = ZERO;
                    state_next = DONE;
                end
            end else begin
                // A zero count in RUN is unreachable; settle in DONE rather than wrap.
                state_next = DONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= ZERO;
            reload <= ZERO;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            reload <= reload_next;
            busy_q <= (state_next == RUN);
            done_q <= (state_next == DONE);
            tc_q   <= tc_next;
        end
    end

    assign out  = count;
    assign busy = busy_q;
    assign done = done_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_down_counter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             enable = 1'b0;
    logic             auto_reload = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] out;
    logic             busy, done, tc;

    int n_checks = 0;
    int n_fail   = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .enable(enable), .auto_reload(auto_reload), .abort(abort),
        .out(out), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_checks++;
        if ({out, busy, done, tc} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: out=%0d busy=%b done=%b tc=%b, want 0 0 0 0", out, busy, done, tc);
        end
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        step();
        n_checks++;
        if ({out, busy, done, tc} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL idle_enable: out=%0d busy=%b done=%b tc=%b, want 0 0 0 0", out, busy, done, tc);
        end
    endtask

    task automatic test_oneshot();
        load = 1'b1; load_value = 8'd5; enable = 1'b1; auto_reload = 1'b0;
        step();
        load = 1'b0;
        n_checks++;
        if (out !== 8'd5 || busy !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_load: out=%0d busy=%b tc=%b, want 5 1 0", out, busy, tc);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (out !== 8'(4 - i) || tc !== (i == 4) || busy !== (i < 4) || done !== (i == 4)) begin
                n_fail++;
                $display("FAIL oneshot_count[%0d]: out=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                         i, out, tc, busy, done, 4 - i, i == 4, i < 4, i == 4);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (out !== 8'd0 || tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot_hold[%0d]: out=%0d tc=%b done=%b busy=%b, want 0 0 1 0", i, out, tc, done, busy);
            end
        end
    endtask

    task automatic test_periodic();
        int exp_seq[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        load = 1'b1; load_value = 8'd3; enable = 1'b1; auto_reload = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (out !== 8'd3 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL periodic_load: out=%0d tc=%b, want 3 0", out, tc);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            n_checks++;
            if (out !== 8'(exp_seq[i]) || tc !== (exp_seq[i] == 3) || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL periodic[%0d]: out=%0d tc=%b busy=%b done=%b, want %0d %b 1 0",
                         i, out, tc, busy, done, exp_seq[i], exp_seq[i] == 3);
            end
        end
    endtask

    task automatic test_pause();
        logic en_seq[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   exp_seq[5] = '{5, 5, 5, 4, 3};
        load = 1'b1; load_value = 8'd6; enable = 1'b1; auto_reload = 1'b0;
        step();
        load = 1'b0;
        n_checks++;
        if (out !== 8'd6) begin
            n_fail++;
            $display("FAIL pause_load: out=%0d, want 6", out);
        end
        for (int i = 0; i < 5; i++) begin
            enable = en_seq[i];
            step();
            n_checks++;
            if (out !== 8'(exp_seq[i]) || tc !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pause[%0d]: out=%0d tc=%b busy=%b, want %0d 0 1", i, out, tc, busy, exp_seq[i]);
            end
        end
    endtask

    task automatic test_load_zero();
        load = 1'b1; load_value = 8'd0; enable = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out !== 8'd0 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL load_zero[%0d]: out=%0d done=%b busy=%b tc=%b, want 0 1 0 0", i, out, done, busy, tc);
            end
            step();
        end
    endtask

    task automatic test_load_on_tc();
        load = 1'b1; load_value = 8'd2; enable = 1'b1; auto_reload = 1'b0;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (out !== 8'd1) begin
            n_fail++;
            $display("FAIL pre_terminal: out=%0d, want 1", out);
        end
        load = 1'b1; load_value = 8'd9;
        step();
        load = 1'b0;
        n_checks++;
        if (out !== 8'd9 || tc !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_beats_tc: out=%0d tc=%b busy=%b, want 9 0 1", out, tc, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if ({out, busy, done, tc} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL abort: out=%0d busy=%b done=%b tc=%b, want 0 0 0 0", out, busy, done, tc);
        end
        step();
        n_checks++;
        if ({out, busy, done, tc} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL idle_after_abort: out=%0d busy=%b done=%b tc=%b, want 0 0 0 0", out, busy, done, tc);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_value = 8'd200; enable = 1'b1; auto_reload = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 50; i++) step();
        n_checks++;
        if (out !== 8'd150 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL before_reset: out=%0d busy=%b, want 150 1", out, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out, busy, done, tc} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset: out=%0d busy=%b done=%b tc=%b, want 0 0 0 0", out, busy, done, tc);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({out, busy, done, tc} !== {8'd0, 3'b000}) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: out=%0d busy=%b done=%b tc=%b, want 0 0 0 0", i, out, busy, done, tc);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; load = 1'b1; load_value = 8'd7;
        step();
        load = 1'b0;
        n_checks++;
        if (out !== 8'd7 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_edge_load: out=%0d busy=%b, want 7 1", out, busy);
        end
    endtask

    // Behavioural model: mode is 0 idle, 1 running, 2 finished.
    task automatic test_random();
        int               mode = 0;
        logic [WIDTH-1:0] m_out = '0;
        logic [WIDTH-1:0] m_reload = '0;
        logic             m_tc;
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            abort       = ($urandom_range(15) == 0);
            load        = ($urandom_range(7) == 0);
            load_value  = ($urandom_range(3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(4));
            enable      = ($urandom_range(3) != 0);
            auto_reload = $urandom_range(1);
            m_tc = 1'b0;
            if (abort) begin
                mode = 0; m_out = '0;
            end else if (load) begin
                m_out = load_value; m_reload = load_value;
                mode = (load_value == 0) ? 2 : 1;
            end else if (mode == 1 && enable) begin
                if (m_out == 1) begin
                    m_tc = 1'b1;
                    if (auto_reload) m_out = m_reload;
                    else begin m_out = '0; mode = 2; end
                end else begin
                    m_out = m_out - 1'b1;
                end
            end
            step();
            n_checks++;
            if (out !== m_out || busy !== (mode == 1) || done !== (mode == 2) || tc !== m_tc) begin
                n_fail++;
                $display("FAIL random[%0d]: out=%0d busy=%b done=%b tc=%b, want %0d %b %b %b",
                         i, out, busy, done, tc, m_out, mode == 1, mode == 2, m_tc);
            end
        end
        abort = 1'b0; load = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_load_zero();
        test_load_on_tc();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
